// File: rtl/pipelined_cla_subtractor_pkg.sv
// pipelined_cla_subtractor_pkg: shared constants and the per-stage pipeline entry record.
//   NIB   - nibble width handled by one stage
//   MAX_W - widest operand the entry record can carry (WIDTH must not exceed it)
package pipelined_cla_subtractor_pkg;
    localparam int NIB = 4;
    localparam int MAX_W = 64;
    // rem_a/rem_b hold operand nibbles not yet consumed, shifted down so the next
    // stage always works on bits [NIB-1:0]; diff fills in nibble by nibble.
    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] rem_a;
        logic [MAX_W-1:0] rem_b;
        logic [MAX_W-1:0] diff;
        logic             borrow;
        logic             sa;
        logic             sb;
    } entry_t;
endpackage

// File: rtl/cla_sub_nibble.sv
// cla_sub_nibble: combinational 4-bit lookahead subtract slice.
//   a, b        - minuend / subtrahend nibble
//   borrow      - borrow into bit 0
//   diff        - a - b - borrow (4 bits)
//   borrow_next - borrow out of bit 3
module cla_sub_nibble
    import pipelined_cla_subtractor_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           borrow,
    output logic [NIB-1:0] diff,
    output logic           borrow_next
);
    logic [NIB-1:0] g, p;
    logic [NIB:0] c;
    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign g = ~a & b;
    assign p = ~(a ^ b);
    assign c[0] = borrow;
    assign c[1] = g[0] | p[0] & c[0];
    assign c[2] = g[1] | p[1] & g[0] | p[1] & p[0] & c[0];
    assign c[3] = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & c[0];
    assign c[4] = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0]
                | p[3] & p[2] & p[1] & p[0] & c[0];
    assign diff = a ^ b ^ c[NIB-1:0];
    assign borrow_next = c[NIB];
endmodule

// File: rtl/pipelined_cla_subtractor.sv
// pipelined_cla_subtractor: valid/ready pipelined subtractor, one lookahead nibble per stage.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - operand handshake (a, b, b_in)
//   out_valid, out_ready- result handshake (diff, b_out, ovf)
//   diff  = a - b - b_in mod 2^WIDTH, b_out = borrow out, ovf = signed overflow
module pipelined_cla_subtractor
    import pipelined_cla_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / NIB;

    entry_t in_e;
    entry_t st  [STAGES];
    entry_t up  [STAGES];
    entry_t nxt [STAGES];
    logic [STAGES:0] rdy;

    assign in_e = '{valid: in_valid, rem_a: MAX_W'(a), rem_b: MAX_W'(b), diff: '0,
                    borrow: b_in, sa: a[WIDTH-1], sb: b[WIDTH-1]};

    // A stage may load when it is empty or its occupant leaves this cycle,
    // so bubbles collapse and a full pipe still streams one per cycle.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            rdy[i] = !st[i].valid || rdy[i+1];
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [NIB-1:0] d;
            logic           bo;
            if (k == 0) begin : g_src
                assign up[k] = in_e;
            end else begin : g_src
                assign up[k] = st[k-1];
            end
            cla_sub_nibble u_nib (
                .a          (up[k].rem_a[NIB-1:0]),
                .b          (up[k].rem_b[NIB-1:0]),
                .borrow     (up[k].borrow),
                .diff       (d),
                .borrow_next(bo)
            );
            assign nxt[k] = '{valid: up[k].valid,
                              rem_a: up[k].rem_a >> NIB,
                              rem_b: up[k].rem_b >> NIB,
                              diff: up[k].diff | (MAX_W'(d) << (NIB * k)),
                              borrow: bo, sa: up[k].sa, sb: up[k].sb};
        end
    endgenerate

    always_ff @(posedge clk)
        for (int i = 0; i < STAGES; i++)
            if (rst)
                st[i] <= '0;
            else if (rdy[i])
                st[i] <= nxt[i];

    assign in_ready  = rdy[0] && !rst;
    assign out_valid = st[STAGES-1].valid;
    assign diff      = st[STAGES-1].diff[WIDTH-1:0];
    assign b_out     = st[STAGES-1].borrow;
    assign ovf       = (st[STAGES-1].sa != st[STAGES-1].sb) && (diff[WIDTH-1] != st[STAGES-1].sa);
endmodule
